// File: rtl/data_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Address split: tag = addr[31:8], index = addr[7:4], word offset = addr[3:2].
package dcache_pkg;

  localparam int unsigned OFFSET_W    = 2;
  localparam int unsigned INDEX_W     = 4;
  localparam int unsigned TAG_W       = 24;
  localparam int unsigned LINE_ADDR_W = 28;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LINE_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_W-1:0] off);
    return line[{off, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU request/response and backing-memory bus of the data cache.
// The cache uses the slave modport; the CPU/memory side uses master.
interface data_cache_if;
  import dcache_pkg::*;

  logic                   is_input_valid;
  logic [31:0]            addr;
  logic                   mem_read;
  logic                   mem_write;
  logic [WORD_W-1:0]      din;
  logic                   is_ready;
  logic                   is_output_valid;
  logic [WORD_W-1:0]      dout;
  logic                   is_hit;

  logic                   mem_req_valid;
  logic                   mem_req_write;
  logic [LINE_ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0]      mem_req_data;
  logic                   mem_req_ready;
  logic                   mem_resp_valid;
  logic [LINE_W-1:0]      mem_resp_data;

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output is_ready, is_output_valid, dout, is_hit,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  is_ready, is_output_valid, dout, is_hit,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

endinterface

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port
// that either installs a whole clean line or updates one word and marks it dirty.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [LINE_W-1:0]   rd_line,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic                line_we,
  input  logic [TAG_W-1:0]    line_tag,
  input  logic [LINE_W-1:0]   line_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data
);

  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [LINE_W-1:0]   lines [NUM_SETS];
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;

  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];
  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
    end else if (word_we) begin
      dirty[wr_index] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[wr_index]  <= line_tag;
      lines[wr_index] <= line_data;
    end else if (word_we) begin
      lines[wr_index][{word_off, 5'b0} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Blocking direct-mapped write-back/write-allocate data cache: hits complete in
// the request cycle, misses run optional writeback then line fill, then replay.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  data_cache_if.slave      bus,
  output logic [CNT_W-1:0] access_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned LINE_BITS = LINE_BYTES * 8;

  state_t               state;
  logic [TAG_W-1:0]     lat_tag;
  logic [INDEX_W-1:0]   lat_index;
  logic                 replay;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_index;
  logic [OFFSET_W-1:0]  req_off;
  logic                 req;
  logic                 hit;
  logic                 complete;
  logic                 unused_addr_bits;

  logic [INDEX_W-1:0]   rd_index;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [LINE_BITS-1:0] rd_line;
  logic [INDEX_W-1:0]   wr_index;
  logic                 line_we;
  logic                 word_we;

  assign req_tag          = bus.addr[31:8];
  assign req_index        = bus.addr[7:4];
  assign req_off          = bus.addr[3:2];
  assign unused_addr_bits = ^bus.addr[1:0];

  assign req      = bus.is_input_valid && (bus.mem_read || bus.mem_write);
  assign rd_index = (state == IDLE) ? req_index : lat_index;
  assign hit      = (state == IDLE) && rd_valid && (rd_tag == req_tag);
  assign complete = req && hit;

  assign bus.is_ready        = (state == IDLE);
  assign bus.is_hit          = hit;
  assign bus.is_output_valid = complete;
  assign bus.dout            = line_word(rd_line, req_off);

  assign line_we  = (state == FILL_WAIT) && bus.mem_resp_valid;
  assign word_we  = complete && bus.mem_write;
  assign wr_index = line_we ? lat_index : req_index;

  dcache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (rd_index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .wr_index  (wr_index),
    .line_we   (line_we),
    .line_tag  (lat_tag),
    .line_data (bus.mem_resp_data),
    .word_we   (word_we),
    .word_off  (req_off),
    .word_data (bus.din)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      lat_tag           <= '0;
      lat_index         <= '0;
      replay            <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_write <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_data  <= '0;
      access_count      <= '0;
      hit_count         <= '0;
    end else begin
      if (complete) begin
        access_count <= access_count + 1'b1;
        if (!replay) hit_count <= hit_count + 1'b1;
      end
      case (state)
        IDLE: begin
          // The held request that missed returns here and hits; it must not count.
          replay <= req && !hit;
          if (req && !hit) begin
            lat_tag           <= req_tag;
            lat_index         <= req_index;
            bus.mem_req_valid <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state            <= WRITEBACK;
              bus.mem_req_write <= 1'b1;
              bus.mem_req_addr  <= {rd_tag, req_index};
              bus.mem_req_data  <= rd_line;
            end else begin
              state            <= FILL_REQ;
              bus.mem_req_write <= 1'b0;
              bus.mem_req_addr  <= {req_tag, req_index};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_req_ready) begin
            state            <= FILL_REQ;
            bus.mem_req_write <= 1'b0;
            bus.mem_req_addr  <= {lat_tag, lat_index};
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_ready) begin
            state             <= FILL_WAIT;
            bus.mem_req_valid <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus queues expected CPU responses and
// memory requests; negedge monitors pop and compare what the cache presents.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] access_count;
  logic [31:0] hit_count;

  data_cache_if bus ();

  data_cache #(
    .LINE_BYTES (16),
    .NUM_SETS   (16),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus),
    .access_count (access_count),
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } cpu_exp_t;

  typedef struct {
    bit           write;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_exp_t;

  cpu_exp_t     cq[$];
  mem_exp_t     mq[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [127:0] mem_lines [logic [27:0]];
  int           rdy_delay = 0;
  int           resp_delay = 3;

  int           wait_cnt = 0;
  int           resp_cnt = 0;
  bit           fill_pending = 1'b0;
  logic [27:0]  fill_addr = '0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Backing memory: ready after rdy_delay waiting cycles, fill data in the
  // resp_delay-th cycle after acceptance. Deliberately blind to reset.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (fill_pending) begin
        if (resp_cnt <= 1) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_lines.exists(fill_addr) ? mem_lines[fill_addr]
                                                           : {4{4'h0, fill_addr}};
          fill_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (bus.mem_req_valid) begin
        if (wait_cnt < rdy_delay) begin
          wait_cnt++;
        end else begin
          bus.mem_req_ready = 1'b1;
          wait_cnt = 0;
          if (bus.mem_req_write) begin
            mem_lines[bus.mem_req_addr] = bus.mem_req_data;
          end else begin
            fill_pending = 1'b1;
            resp_cnt     = resp_delay;
            fill_addr    = bus.mem_req_addr;
          end
        end
      end
    end
  end

  logic         held_v = 1'b0;
  logic         held_w;
  logic [27:0]  held_a;
  logic [127:0] held_d;
  mem_exp_t     me;

  always @(negedge clk) begin
    if (bus.mem_req_valid) begin
      check("busy_not_ready", 128'(bus.is_ready), 128'(1'b0));
      if (held_v) begin
        check("req_write_stable", 128'(bus.mem_req_write), 128'(held_w));
        check("req_addr_stable", 128'(bus.mem_req_addr), 128'(held_a));
        check("req_data_stable", bus.mem_req_data, held_d);
      end
      if (bus.mem_req_ready) begin
        held_v = 1'b0;
        if (mq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mem_req_unexpected: got addr %h write %0d expected none",
                   bus.mem_req_addr, bus.mem_req_write);
        end else begin
          me = mq.pop_front();
          check("mem_req_write", 128'(bus.mem_req_write), 128'(me.write));
          check("mem_req_addr", 128'(bus.mem_req_addr), 128'(me.addr));
          if (me.write) check("mem_req_data", bus.mem_req_data, me.data);
        end
      end else begin
        held_v = 1'b1;
        held_w = bus.mem_req_write;
        held_a = bus.mem_req_addr;
        held_d = bus.mem_req_data;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  cpu_exp_t ce;

  always @(negedge clk) begin
    if (bus.is_output_valid) begin
      check("hit_with_output", 128'(bus.is_hit), 128'(1'b1));
      if (cq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL cpu_resp_unexpected: got addr %h expected none", bus.addr);
      end else begin
        ce = cq.pop_front();
        if (ce.is_load) check("load_data", 128'(bus.dout), 128'(ce.data));
      end
    end
  end

  // Called and returns at posedge+1; leaves the request low at that time.
  task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input int exp_lat, input string name);
    int lat = 0;
    cq.push_back('{is_load: !wr, data: exp_d});
    bus.is_input_valid = 1'b1;
    bus.addr           = a;
    bus.mem_read       = !wr;
    bus.mem_write      = wr;
    bus.din            = d;
    forever begin
      @(negedge clk);
      if (bus.is_output_valid) break;
      lat++;
      if (lat > 200) break;
    end
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    @(posedge clk);
    #1;
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
  endtask

  task automatic check_counts(input string name, input int acc, input int hits);
    check({name, "_access_count"}, 128'(access_count), 128'(acc));
    check({name, "_hit_count"}, 128'(hit_count), 128'(hits));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b1;
    bus.is_input_valid = 1'b0;
    bus.addr           = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.din            = '0;
    mem_lines[28'h1]   = {32'h44, 32'h33, 32'h22, 32'h11};
    mem_lines[28'h11]  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1 rst_n = 1'b0;
    #11;
    check("reset_req_valid", 128'(bus.mem_req_valid), 128'(1'b0));
    check("reset_ready", 128'(bus.is_ready), 128'(1'b1));
    check_counts("reset", 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss: FILL_REQ (1) + FILL_WAIT (3) + miss cycle -> 5 stalled cycles
    mq.push_back('{write: 1'b0, addr: 28'h1, data: '0});
    cpu_op(1'b0, 32'h10, 32'h0, 32'h11, 5, "cold_load");
    check_counts("cold_load", 1, 0);

    cpu_op(1'b1, 32'h14, 32'hDEADBEEF, 32'h0, 0, "store_hit");
    cpu_op(1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 0, "load_after_store");
    check_counts("store_load", 3, 2);

    // Dirty eviction with ready held off 5 cycles per request: 1 + 6 + 6 + 3
    rdy_delay = 5;
    mq.push_back('{write: 1'b1, addr: 28'h1,
                   data: {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}});
    mq.push_back('{write: 1'b0, addr: 28'h11, data: '0});
    cpu_op(1'b0, 32'h110, 32'h0, 32'hA0, 16, "dirty_evict");
    check_counts("dirty_evict", 4, 2);
    rdy_delay = 0;

    mq.push_back('{write: 1'b0, addr: 28'h1, data: '0});
    cpu_op(1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 5, "clean_evict");
    check_counts("clean_evict", 5, 2);

    cpu_op(1'b0, 32'h10, 32'h0, 32'h11, 0, "b2b_w0");
    cpu_op(1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 0, "b2b_w1");
    cpu_op(1'b0, 32'h18, 32'h0, 32'h33, 0, "b2b_w2");
    cpu_op(1'b0, 32'h1C, 32'h0, 32'h44, 0, "b2b_w3");
    check_counts("b2b", 9, 6);

    // Reset in FILL_WAIT of line 0x23; its response arrives after reset.
    resp_delay = 10;
    mq.push_back('{write: 1'b0, addr: 28'h23, data: '0});
    bus.is_input_valid = 1'b1;
    bus.addr           = 32'h230;
    bus.mem_read       = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midfill_reset_req_valid", 128'(bus.mem_req_valid), 128'(1'b0));
    check("midfill_reset_ready", 128'(bus.is_ready), 128'(1'b1));
    check_counts("midfill_reset", 0, 0);
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    resp_delay = 3;
    mq.push_back('{write: 1'b0, addr: 28'h1, data: '0});
    cpu_op(1'b0, 32'h10, 32'h0, 32'h11, 5, "miss_after_reset");
    mq.push_back('{write: 1'b0, addr: 28'h23, data: '0});
    cpu_op(1'b0, 32'h230, 32'h0, 32'h23, 5, "late_resp_ignored");
    check_counts("after_reset", 2, 0);

    // Valid with neither read nor write is not a request.
    bus.is_input_valid = 1'b1;
    bus.addr           = 32'h10;
    @(negedge clk);
    check("noop_no_output", 128'(bus.is_output_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    bus.is_input_valid = 1'b0;
    check_counts("noop", 2, 0);

    repeat (3) @(posedge clk);
    check("cpu_queue_drained", 128'(cq.size()), 128'(0));
    check("mem_queue_drained", 128'(mq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Blocking, direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the backing data memory. A hit completes in the request cycle. A miss drives an optional dirty-line writeback, then a line fill. During that time the CPU stalls its pipeline and holds the request stable. Hit and access counters feed the performance reporting.

Parameters:
LINE_BYTES, 16, bytes per line (4 words); offset = addr[3:2]
NUM_SETS, 16, number of lines; index = addr[7:4], tag = addr[31:8]
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
is_input_valid  in  1  CPU request present
addr  in  32  byte address; bits [1:0] ignored
mem_read  in  1  load request
mem_write  in  1  store request (never together with mem_read)
din  in  32  store data
is_ready  out  1  cache in IDLE and able to accept
is_output_valid  out  1  request completes this cycle
dout  out  32  load data; valid when is_output_valid && mem_read
is_hit  out  1  tag match on valid line (combinational, IDLE only)
mem_req_valid  out  1  backing-memory request
mem_req_write  out  1  1 = writeback, 0 = fill
mem_req_addr  out  28  line address {tag,index}
mem_req_data  out  128  line data for writeback
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  fill data present
mem_resp_data  in  128  fill line; word0 in [31:0]
access_count  out  CNT_W  completed accesses
hit_count  out  CNT_W  accesses that hit on first presentation

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all valid/dirty bits cleared; counters=0.
  - mem_req_valid=0 immediately, including mid-writeback or mid-fill.
  - Any outstanding memory response is dropped; it is ignored after reset deasserts.
- States: IDLE, WRITEBACK, FILL_REQ, FILL_WAIT.
- IDLE, is_ready=1:
  - valid request and hit: is_output_valid=1 in the same cycle; dout = selected word.
  - Hit on a store: the word is written and dirty set at the clock edge.
  - valid request and miss: is_output_valid=0; tag/index/offset latched.
  - Miss next state: WRITEBACK if the victim is valid and dirty, else FILL_REQ.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1, addr={victim tag, index}, data = victim line.
  - On mem_req_ready: go to FILL_REQ.
- FILL_REQ:
  - mem_req_valid=1, mem_req_write=0, addr={latched tag, index}.
  - On mem_req_ready: go to FILL_WAIT.
- FILL_WAIT:
  - On mem_resp_valid: the line is written with tag, valid=1, dirty=0; go to IDLE.
  - The CPU's held request then hits, giving a miss penalty of writeback + fill + 1 cycle.
- In every non-IDLE state: is_ready=0, is_output_valid=0, is_hit=0.
- mem_resp_valid outside FILL_WAIT is ignored.
- mem_req_* outputs are held stable until mem_req_ready is seen.
- Counters:
  - access_count increments on every is_output_valid.
  - hit_count increments only on a hit whose request was not preceded by a miss on the same latched request. A replay after a fill does not count as a hit.
  - Both counters wrap modulo 2^CNT_W.
- is_input_valid with neither mem_read nor mem_write: treated as no request.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, FILL_REQ, FILL_WAIT);
  - the derived widths OFFSET_W=2, INDEX_W=4, TAG_W=24;
  - the line-address width of 28.
- One sub-module, dcache_array: tag/valid/dirty/data storage with one read port and a write port that takes either a whole line (fill) or a single word plus dirty (store hit).
- FSM, counters and port muxing live in data_cache.

Test Plan:
- Cold load at 0x0000_0010, memory fill line {0x44,0x33,0x22,0x11} with a 3-cycle resp delay:
  - FILL_REQ then FILL_WAIT, then one IDLE cycle with dout=0x11 and is_output_valid=1;
  - access_count=1, hit_count=0.
- Store 0xDEAD_BEEF to 0x14 after the above:
  - same-cycle is_output_valid; the line becomes dirty;
  - a load from 0x14 next cycle returns 0xDEAD_BEEF; hit_count=2.
- Load 0x0000_0110 (same index, new tag) with the dirty line present:
  - WRITEBACK with mem_req_addr=0x000_0001 and word1=0xDEAD_BEEF;
  - then a fill from 0x000_0011; no writeback occurs on the next clean eviction.
- mem_req_ready held low for 5 cycles in WRITEBACK:
  - mem_req_valid, addr and data stay stable;
  - is_ready=0 throughout.
- reset pulsed low during FILL_WAIT:
  - mem_req_valid=0 and counters=0 without waiting for a clock edge;
  - a late mem_resp_valid is ignored; a load to a previously cached address misses.
- Back-to-back hits on 4 words of one line with is_input_valid held high:
  - is_output_valid every cycle; access_count increments by 4.
